// File: rtl/mood_arbiter.sv
// ============================================================================
//  Module      : mood_arbiter
//  Description : Round-robin arbiter and dwell scheduler. Shares one
//                mood-light response register among N_REQ requesters. The
//                granted requester's 2-bit mood code is driven to the
//                datapath for a programmable number of cycles, and then the
//                next requester is chosen.
//  Ports       : clk          - system clock, rising edge
//                reset        - asynchronous, active-high reset
//                req          - per-requester request level
//                mood_in      - packed mood codes, requester i at [2i+1:2i]
//                dwell_cycles - hold time per grant (0 treated as 1)
//                grant        - one-hot, single-cycle new-grant pulse
//                owner        - index of the current or last granted requester
//                mood_out     - mood code driven to the datapath
//                mood_valid   - high while a grant's dwell is active
//                busy         - high in the DWELL state
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mood_arbiter #(
  parameter int N_REQ   = 4,
  parameter int OWNER_W = 2,
  parameter int DWELL_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [2*N_REQ-1:0]   mood_in,
  input  logic [DWELL_W-1:0]   dwell_cycles,
  output logic [N_REQ-1:0]     grant,
  output logic [OWNER_W-1:0]   owner,
  output logic [1:0]           mood_out,
  output logic                 mood_valid,
  output logic                 busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DWELL = 1'b1;

  logic [0:0]         state_q,  state_d;
  logic [DWELL_W-1:0] cnt_q,    cnt_d;
  logic [N_REQ-1:0]   grant_q,  grant_d;
  logic [OWNER_W-1:0] owner_q,  owner_d;
  logic [1:0]         mood_q,   mood_d;
  logic               valid_q,  valid_d;

  // Per-requester mood codes as an array so the winner can select by index.
  logic [1:0] codes [N_REQ];

  genvar g;
  generate
    for (g = 0; g < N_REQ; g++) begin : g_unpack
      assign codes[g] = mood_in[2*g+1:2*g];
    end
  endgenerate

  // Rotating-priority search: the first requester after the current owner
  // wins, wrapping around so the owner itself is considered last.
  logic               win_found;
  logic [OWNER_W-1:0] win_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = owner_q;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!win_found && req[i] && (((int'(owner_q) + k) % N_REQ) == i)) begin
          win_found = 1'b1;
          win_idx   = OWNER_W'(i);
        end
      end
    end
  end

  logic [DWELL_W-1:0] dwell_load;
  logic               arb_now;

  // A dwell of zero still has to produce one valid cycle.
  assign dwell_load = (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;

  // Arbitration happens in IDLE and on the last cycle of a dwell, so that
  // back-to-back grants leave no idle gap.
  assign arb_now = (state_q == ST_IDLE) || (cnt_q == DWELL_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = '0;
    owner_d = owner_q;
    mood_d  = mood_q;
    valid_d = valid_q;
    if (arb_now) begin
      if (win_found) begin
        state_d = ST_DWELL;
        cnt_d   = dwell_load;
        grant_d = N_REQ'(1) << win_idx;
        owner_d = win_idx;
        mood_d  = codes[win_idx];
        valid_d = 1'b1;
      end else begin
        // mood_out keeps its last code when the arbiter goes idle.
        state_d = ST_IDLE;
        cnt_d   = '0;
        valid_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      // Last owner N_REQ-1 gives requester 0 top priority after reset.
      owner_q <= OWNER_W'(N_REQ - 1);
      mood_q  <= 2'b00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      mood_q  <= mood_d;
      valid_q <= valid_d;
    end
  end

  assign grant      = grant_q;
  assign owner      = owner_q;
  assign mood_out   = mood_q;
  assign mood_valid = valid_q;
  assign busy       = (state_q == ST_DWELL);

endmodule

`default_nettype wire

// File: tb/tb_mood_arbiter.sv
// ============================================================================
//  Module      : tb_mood_arbiter
//  Description : Directed self-checking bench for mood_arbiter (N_REQ=4).
//                Outputs are compared as one packed word
//                {grant, owner, mood_out, mood_valid, busy}.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mood_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [7:0] mood_in;
  logic [7:0] dwell_cycles;
  logic [3:0] grant;
  logic [1:0] owner;
  logic [1:0] mood_out;
  logic       mood_valid;
  logic       busy;

  int vectors;
  int miscompares;

  logic [9:0] obs;
  assign obs = {grant, owner, mood_out, mood_valid, busy};

  mood_arbiter #(
    .N_REQ  (4),
    .OWNER_W(2),
    .DWELL_W(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .mood_in     (mood_in),
    .dwell_cycles(dwell_cycles),
    .grant       (grant),
    .owner       (owner),
    .mood_out    (mood_out),
    .mood_valid  (mood_valid),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    step();
    #2;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    req          = 4'b0000;
    mood_in      = 8'h00;
    dwell_cycles = 8'd1;
    #2;
    vectors++;
    if (obs !== {4'b0000, 2'd3, 2'b00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got %b want %b", obs, {4'b0000, 2'd3, 2'b00, 1'b0, 1'b0});
    end
    step();
    #2;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++;
      if (obs !== {4'b0000, 2'd3, 2'b00, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL idle_no_req c%0d: got %b want %b", c, obs, {4'b0000, 2'd3, 2'b00, 1'b0, 1'b0});
      end
    end
  endtask

  task automatic test_single();
    logic [9:0] exp;
    req          = 4'b0001;
    mood_in      = 8'b0000_0010;
    dwell_cycles = 8'd3;
    for (int c = 0; c < 3; c++) begin
      step();
      exp = {(c == 0) ? 4'b0001 : 4'b0000, 2'd0, 2'b10, 1'b1, 1'b1};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL single c%0d: got %b want %b", c, obs, exp);
      end
    end
    // Still requesting: re-granted with no gap.
    step();
    vectors++;
    if (obs !== {4'b0001, 2'd0, 2'b10, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL single_regrant: got %b want %b", obs, {4'b0001, 2'd0, 2'b10, 1'b1, 1'b1});
    end
    req = 4'b0000;
    step();
    step();
    vectors++;
    if (obs !== {4'b0000, 2'd0, 2'b10, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL single_hold_after_drop: got %b want %b", obs, {4'b0000, 2'd0, 2'b10, 1'b1, 1'b1});
    end
    step();
    vectors++;
    if (obs !== {4'b0000, 2'd0, 2'b10, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL single_to_idle: got %b want %b", obs, {4'b0000, 2'd0, 2'b10, 1'b0, 1'b0});
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_own [5];
    logic [9:0] exp;
    exp_own = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    req          = 4'b1111;
    mood_in      = 8'b11_10_01_00;
    dwell_cycles = 8'd2;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 2; c++) begin
        step();
        // Codes were chosen equal to the requester index.
        exp = {(c == 0) ? (4'b0001 << exp_own[k]) : 4'b0000, exp_own[k], exp_own[k], 1'b1, 1'b1};
        vectors++;
        if (obs !== exp) begin
          miscompares++;
          $display("FAIL round_robin k%0d c%0d: got %b want %b", k, c, obs, exp);
        end
      end
    end
    req = 4'b0000;
    step();
    vectors++;
    if (obs !== {4'b0000, 2'd0, 2'b00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL round_robin_idle: got %b want %b", obs, {4'b0000, 2'd0, 2'b00, 1'b0, 1'b0});
    end
  endtask

  task automatic test_dwell_zero();
    logic [9:0] exp;
    req          = 4'b0110;
    mood_in      = 8'b00_10_01_00;
    dwell_cycles = 8'd0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (c % 2 == 0) exp = {4'b0010, 2'd1, 2'b01, 1'b1, 1'b1};
      else            exp = {4'b0100, 2'd2, 2'b10, 1'b1, 1'b1};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL dwell_zero c%0d: got %b want %b", c, obs, exp);
      end
    end
    req = 4'b0000;
    step();
    vectors++;
    if (obs !== {4'b0000, 2'd2, 2'b10, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL dwell_zero_idle: got %b want %b", obs, {4'b0000, 2'd2, 2'b10, 1'b0, 1'b0});
    end
  endtask

  task automatic test_freeze();
    logic [9:0] exp;
    req          = 4'b0100;
    mood_in      = 8'b00_11_00_00;
    dwell_cycles = 8'd5;
    for (int c = 0; c < 5; c++) begin
      step();
      exp = {(c == 0) ? 4'b0100 : 4'b0000, 2'd2, 2'b11, 1'b1, 1'b1};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL freeze c%0d: got %b want %b", c, obs, exp);
      end
      if (c == 1) begin
        mood_in      = 8'b00_00_00_00;
        req          = 4'b0000;
        dwell_cycles = 8'd9;
      end
    end
    step();
    vectors++;
    if (obs !== {4'b0000, 2'd2, 2'b11, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL freeze_idle: got %b want %b", obs, {4'b0000, 2'd2, 2'b11, 1'b0, 1'b0});
    end
  endtask

  task automatic test_reset_mid_dwell();
    logic [9:0] exp;
    req          = 4'b0010;
    mood_in      = 8'b00_00_10_00;
    dwell_cycles = 8'd200;
    for (int c = 0; c < 50; c++) begin
      step();
      exp = {(c == 0) ? 4'b0010 : 4'b0000, 2'd1, 2'b10, 1'b1, 1'b1};
      if (c == 0 || c == 49) begin
        vectors++;
        if (obs !== exp) begin
          miscompares++;
          $display("FAIL mid_dwell c%0d: got %b want %b", c, obs, exp);
        end
      end
      if (c == 0) req = 4'b0000;
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (obs !== {4'b0000, 2'd3, 2'b00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_async_abort: got %b want %b", obs, {4'b0000, 2'd3, 2'b00, 1'b0, 1'b0});
    end
    req = 4'b0011;
    step();
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (obs !== {4'b0000, 2'd3, 2'b00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_release_no_pulse: got %b want %b", obs, {4'b0000, 2'd3, 2'b00, 1'b0, 1'b0});
    end
    step();
    vectors++;
    if (obs !== {4'b0001, 2'd0, 2'b00, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL post_reset_r0_first: got %b want %b", obs, {4'b0001, 2'd0, 2'b00, 1'b1, 1'b1});
    end
  endtask

  task automatic test_long_dwell();
    int n;
    req = 4'b0000;
    do_reset();
    req          = 4'b0001;
    mood_in      = 8'b00_00_00_01;
    dwell_cycles = 8'd255;
    step();
    req = 4'b0000;
    n = 0;
    while (mood_valid === 1'b1 && n < 300) begin
      n++;
      step();
    end
    vectors++;
    if (n !== 255) begin
      miscompares++;
      $display("FAIL long_dwell_cycles: got %0d want 255", n);
    end
    vectors++;
    if (obs !== {4'b0000, 2'd0, 2'b01, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL long_dwell_idle: got %b want %b", obs, {4'b0000, 2'd0, 2'b01, 1'b0, 1'b0});
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_dwell_zero();
    test_freeze();
    test_reset_mid_dwell();
    test_long_dwell();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
